// File: rtl/lx32_pipe_pkg.sv
// Shared types for lx32 pipeline helpers.
// The skid buffer state encoding doubles as its occupancy count.
package lx32_pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/reg_generic.sv
// Enabled data register with asynchronous active-high clear.
module reg_generic #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_buf.sv
// Two-entry valid/ready skid buffer; in_ready and out_valid decode registered state only,
// so no combinational path crosses the buffer in either direction.
module pipe_skid_buf
  import lx32_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  skid_state_e      state_q, state_d;
  logic             load_main, load_skid;
  logic             in_fire, out_fire;
  logic [WIDTH-1:0] main_d, main_q, skid_q;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign occupancy = state_q;
  assign out_data  = main_q;

  // Draining FULL promotes the skid entry; otherwise main is refilled from the producer.
  assign main_d = (state_q == FULL) ? skid_q : in_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            load_main = 1'b1;
            state_d   = BUSY;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            load_main = 1'b1;
          end else if (in_fire) begin
            load_skid = 1'b1;
            state_d   = FULL;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            load_main = 1'b1;
            state_d   = BUSY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  reg_generic #(
    .WIDTH(WIDTH)
  ) u_main (
    .clk(clk),
    .rst(rst),
    .en (load_main),
    .d  (main_d),
    .q  (main_q)
  );

  reg_generic #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk(clk),
    .rst(rst),
    .en (load_skid),
    .d  (in_data),
    .q  (skid_q)
  );

endmodule

// File: tb/tb_pipe_skid_buf.sv
// Directed bench for pipe_skid_buf at WIDTH=16.
module tb_pipe_skid_buf;

  localparam int unsigned WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;

  int checks   = 0;
  int failures = 0;

  pipe_skid_buf #(
    .WIDTH(WIDTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic ov, input logic ir,
                              input logic [1:0] occ);
    check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov});
    check({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, ir});
    check({tag, ".occupancy"}, {30'd0, occupancy}, {30'd0, occ});
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    step();
    step();
    expect_state("reset", 1'b0, 1'b1, 2'd0);
    check("reset.out_data", {16'd0, out_data}, 32'h0000);
    rst = 1'b0;

    // Single beat with 1-cycle latency
    in_valid  = 1'b1;
    in_data   = 16'hA5A5;
    out_ready = 1'b1;
    step();
    expect_state("single", 1'b1, 1'b1, 2'd1);
    check("single.out_data", {16'd0, out_data}, 32'hA5A5);
    in_valid = 1'b0;
    step();
    expect_state("single_drain", 1'b0, 1'b1, 2'd0);

    // Stall fills both entries, then drains in order
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h1111;
    step();
    expect_state("stall1", 1'b1, 1'b1, 2'd1);
    in_data = 16'h2222;
    step();
    expect_state("stall2", 1'b1, 1'b0, 2'd2);
    check("stall2.out_data", {16'd0, out_data}, 32'h1111);
    in_valid = 1'b0;
    step();
    expect_state("stall_hold", 1'b1, 1'b0, 2'd2);
    check("stall_hold.out_data", {16'd0, out_data}, 32'h1111);
    out_ready = 1'b1;
    step();
    expect_state("drain1", 1'b1, 1'b1, 2'd1);
    check("drain1.out_data", {16'd0, out_data}, 32'h2222);
    step();
    expect_state("drain2", 1'b0, 1'b1, 2'd0);

    // Streaming: one beat per cycle, no bubbles
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(i);
      step();
      expect_state($sformatf("stream%0d", i), 1'b1, 1'b1, 2'd1);
      check($sformatf("stream%0d.out_data", i), {16'd0, out_data}, 32'(i));
    end
    in_valid = 1'b0;
    step();
    expect_state("stream_end", 1'b0, 1'b1, 2'd0);

    // Flush from FULL while a beat is offered
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h3333;
    step();
    in_data = 16'h4444;
    step();
    expect_state("pre_flush", 1'b1, 1'b0, 2'd2);
    in_data = 16'hFFFF;
    flush   = 1'b1;
    step();
    expect_state("flush", 1'b0, 1'b1, 2'd0);
    flush    = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'h5555;
    step();
    check("post_flush1.out_data", {16'd0, out_data}, 32'h5555);
    in_data = 16'h6666;
    step();
    expect_state("post_flush_full", 1'b1, 1'b0, 2'd2);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("post_flush2.out_data", {16'd0, out_data}, 32'h6666);
    step();
    expect_state("post_flush_empty", 1'b0, 1'b1, 2'd0);

    // Asynchronous reset mid-cycle while FULL
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h7777;
    step();
    in_data = 16'h8888;
    step();
    in_valid = 1'b0;
    expect_state("pre_async", 1'b1, 1'b0, 2'd2);
    #2;
    rst = 1'b1;
    #1;
    expect_state("async_rst", 1'b0, 1'b1, 2'd0);
    check("async_rst.out_data", {16'd0, out_data}, 32'h0000);
    #1;
    rst = 1'b0;
    step();
    expect_state("after_async", 1'b0, 1'b1, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
